// File: rtl/tl_ram_responder_if.sv
// TileLink-UL A/D channel bundle between a requester and tl_ram_responder.
// master drives A and d_ready; slave drives a_ready and D.
interface tl_ram_responder_if;
    logic        auto_in_a_valid;
    logic        auto_in_a_ready;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_param;
    logic [3:0]  auto_in_a_bits_size;
    logic [5:0]  auto_in_a_bits_source;
    logic [28:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;

    logic        auto_in_d_valid;
    logic        auto_in_d_ready;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [3:0]  auto_in_d_bits_size;
    logic [5:0]  auto_in_d_bits_source;
    logic        auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;

    modport master (
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
        output auto_in_a_bits_size, auto_in_a_bits_source,
        output auto_in_a_bits_address, auto_in_a_bits_mask,
        output auto_in_a_bits_data, auto_in_a_bits_corrupt,
        input  auto_in_a_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
        input  auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
        input  auto_in_d_bits_denied, auto_in_d_bits_data,
        input  auto_in_d_bits_corrupt,
        output auto_in_d_ready
    );

    modport slave (
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
        input  auto_in_a_bits_size, auto_in_a_bits_source,
        input  auto_in_a_bits_address, auto_in_a_bits_mask,
        input  auto_in_a_bits_data, auto_in_a_bits_corrupt,
        output auto_in_a_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
        output auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
        output auto_in_d_bits_denied, auto_in_d_bits_data,
        output auto_in_d_bits_corrupt,
        input  auto_in_d_ready
    );
endinterface

// File: rtl/tl_ram_responder.sv
// TileLink-UL RAM slave: 64-bit words, one-deep D holding register,
// saturating count of denied responses.
module tl_ram_responder #(
    parameter int unsigned DEPTH = 32,
    parameter logic [28:0] BASE  = 29'h0
) (
    input  logic              clock,
    input  logic              reset,
    tl_ram_responder_if.slave tl,
    output logic [7:0]        error_count
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [29:0] SPAN = 30'(DEPTH * 8);

    logic [1:0]    r_sync;
    logic          r_d_valid;
    logic [2:0]    r_d_opcode;
    logic [3:0]    r_d_size;
    logic [5:0]    r_d_source;
    logic          r_d_denied;
    logic          r_d_corrupt;
    logic [63:0]   r_d_data;
    logic [7:0]    r_err;
    logic [63:0]   r_mem [DEPTH];

    logic          w_run;
    logic          w_a_ready;
    logic          w_accept;
    logic          w_d_fire;
    logic [29:0]   w_off;
    logic [IW-1:0] w_idx;
    logic          w_in_range;
    logic          w_aligned;
    logic          w_is_get;
    logic          w_is_put;
    logic          w_legal;
    logic          w_get_ok;
    logic          w_put_ok;
    logic          w_we;
    logic [2:0]    w_n_op;
    logic          w_n_den;
    logic          w_n_cor;
    logic [63:0]   w_n_data;
    logic          w_unused;

    // Accepts are held off until the deasserted reset has crossed two flops.
    assign w_run     = r_sync[1];
    assign w_a_ready = w_run && (!r_d_valid || tl.auto_in_d_ready);
    assign w_accept  = tl.auto_in_a_valid && w_a_ready;
    assign w_d_fire  = r_d_valid && tl.auto_in_d_ready;

    // Below-BASE addresses wrap to a huge offset and fail the span test.
    assign w_off      = {1'b0, tl.auto_in_a_bits_address} - {1'b0, BASE};
    assign w_idx      = w_off[IW+2:3];
    assign w_in_range = w_off < SPAN;

    assign w_is_get = tl.auto_in_a_bits_opcode == 3'd4;
    assign w_is_put = tl.auto_in_a_bits_opcode == 3'd0
                   || tl.auto_in_a_bits_opcode == 3'd1;

    always_comb begin
        w_aligned = 1'b0;
        unique case (tl.auto_in_a_bits_size)
            4'd0:    w_aligned = 1'b1;
            4'd1:    w_aligned = tl.auto_in_a_bits_address[0] == 1'b0;
            4'd2:    w_aligned = tl.auto_in_a_bits_address[1:0] == 2'b0;
            4'd3:    w_aligned = tl.auto_in_a_bits_address[2:0] == 3'b0;
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_legal  = (w_is_get || w_is_put) && w_aligned && w_in_range;
    assign w_get_ok = w_is_get && w_legal;
    assign w_put_ok = w_is_put && w_legal && !tl.auto_in_a_bits_corrupt;
    assign w_we     = w_accept && w_put_ok;

    always_comb begin
        w_n_op   = 3'd0;
        w_n_den  = 1'b0;
        w_n_cor  = 1'b0;
        w_n_data = 64'h0;
        unique case (1'b1)
            w_get_ok: begin
                w_n_op   = 3'd1;
                w_n_data = r_mem[w_idx];
            end
            w_is_get && !w_legal: begin
                w_n_op  = 3'd1;
                w_n_den = 1'b1;
                w_n_cor = 1'b1;
            end
            w_put_ok: begin
                w_n_den = 1'b0;
            end
            default: begin
                w_n_den = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], 1'b1};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'd0;
            r_d_size    <= 4'd0;
            r_d_source  <= 6'd0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_d_data    <= 64'h0;
        end else if (w_accept) begin
            r_d_valid   <= 1'b1;
            r_d_opcode  <= w_n_op;
            r_d_size    <= tl.auto_in_a_bits_size;
            r_d_source  <= tl.auto_in_a_bits_source;
            r_d_denied  <= w_n_den;
            r_d_corrupt <= w_n_cor;
            r_d_data    <= w_n_data;
        end else if (w_d_fire) begin
            r_d_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_err <= 8'h00;
        else if (w_d_fire && r_d_denied && r_err != 8'hFF)
            r_err <= r_err + 8'h01;
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int b = 0; b < 8; b++) begin
                if (tl.auto_in_a_bits_mask[b])
                    r_mem[w_idx][b*8 +: 8] <= tl.auto_in_a_bits_data[b*8 +: 8];
            end
        end
    end

    assign w_unused = ^{tl.auto_in_a_bits_param, w_off[29:IW+3], w_off[2:0]};

    assign tl.auto_in_a_ready        = w_a_ready;
    assign tl.auto_in_d_valid        = r_d_valid;
    assign tl.auto_in_d_bits_opcode  = r_d_opcode;
    assign tl.auto_in_d_bits_param   = 2'd0;
    assign tl.auto_in_d_bits_size    = r_d_size;
    assign tl.auto_in_d_bits_source  = r_d_source;
    assign tl.auto_in_d_bits_sink    = 1'b0;
    assign tl.auto_in_d_bits_denied  = r_d_denied;
    assign tl.auto_in_d_bits_data    = r_d_data;
    assign tl.auto_in_d_bits_corrupt = r_d_corrupt;
    assign error_count               = r_err;
endmodule
